// File: rtl/conway_pkg.sv
// Shared types and board geometry for the Game of Life controller and cell array.
package conway_pkg;

  localparam int unsigned BOARD_ROWS = 32;
  localparam int unsigned BOARD_COLS = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_STEP
  } seq_state_t;

endpackage

// File: rtl/conway_prescaler.sv
// Loadable down-counter that paces generations in free-run; tick flags that the
// value being registered this edge is zero.
module conway_prescaler #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  output logic             tick
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload;

  always_comb begin
    reload     = (period > WIDTH'(1)) ? period - WIDTH'(1) : '0;
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = reload;
    end else if (en) begin
      count_next = (count == '0) ? reload : count - WIDTH'(1);
    end
    tick = !clear && (load || en) && (count_next == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/conway_sequencer.sv
// Generation controller: drives the board-wide cell rst/ena strobes for clear,
// single-step and rate-limited free-run with an optional generation limit.
module conway_sequencer #(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned GEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_clear,
  input  logic                cmd_run,
  input  logic                cmd_step,
  input  logic                cmd_stop,
  input  logic [PERIOD_W-1:0] period,
  input  logic [GEN_W-1:0]    gen_limit,
  output logic                board_rst,
  output logic                board_ena,
  output logic                busy,
  output logic                done,
  output logic [GEN_W-1:0]    gen_count
);

  import conway_pkg::*;

  seq_state_t       state;
  seq_state_t       state_next;
  logic             pre_load;
  logic             pre_en;
  logic             pre_clear;
  logic             tick;
  logic             ena_next;
  logic             done_next;
  logic [GEN_W-1:0] count_eff;
  logic [GEN_W-1:0] count_inc;
  logic             limit_hit;

  assign pre_load  = (state == S_IDLE) && !cmd_stop && !cmd_clear && !cmd_step && cmd_run;
  assign pre_en    = (state == S_RUN) && !cmd_stop && !cmd_clear;
  assign pre_clear = !(pre_load || pre_en);

  conway_prescaler #(
    .WIDTH (PERIOD_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (pre_clear),
    .load   (pre_load),
    .en     (pre_en),
    .period (period),
    .tick   (tick)
  );

  // gen_count only advances after a strobe cycle, so count the one in flight
  assign count_eff = gen_count + GEN_W'(board_ena);
  assign count_inc = count_eff + GEN_W'(1);
  assign limit_hit = (gen_limit != '0) && (count_inc == gen_limit);

  always_comb begin
    state_next = state;
    ena_next   = 1'b0;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_stop) begin
          state_next = S_IDLE;
        end else if (cmd_clear) begin
          state_next = S_CLEAR;
        end else if (cmd_step) begin
          state_next = S_STEP;
          ena_next   = 1'b1;
        end else if (cmd_run) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (cmd_stop) begin
          state_next = S_IDLE;
        end else if (cmd_clear) begin
          state_next = S_CLEAR;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if ((pre_load || pre_en) && tick) begin
      ena_next = 1'b1;
      if (limit_hit) begin
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      board_rst <= 1'b1;
      board_ena <= 1'b0;
      done      <= 1'b0;
      gen_count <= '0;
    end else begin
      state     <= state_next;
      board_rst <= (state_next == S_CLEAR);
      board_ena <= ena_next;
      done      <= done_next;
      if (state_next == S_CLEAR) begin
        gen_count <= '0;
      end else if (board_ena) begin
        gen_count <= gen_count + GEN_W'(1);
      end
    end
  end

  assign busy = (state == S_RUN) || (state == S_STEP);

endmodule

// File: tb/tb_conway_sequencer.sv
// Directed bench for conway_sequencer: strobe cycles are queued when commands are
// issued and matched by a negedge monitor; quiescent state is checked inline.
module tb_conway_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_clear = 1'b0;
  logic       cmd_run = 1'b0;
  logic       cmd_step = 1'b0;
  logic       cmd_stop = 1'b0;
  logic [7:0] period = '0;
  logic [3:0] gen_limit = '0;
  logic       board_rst;
  logic       board_ena;
  logic       busy;
  logic       done;
  logic [3:0] gen_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t;
  bit mon_on = 1'b0;
  bit mon_rst = 1'b0;

  int ena_q[$];
  int rst_q[$];
  int done_q[$];

  conway_sequencer #(
    .PERIOD_W (8),
    .GEN_W    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_clear (cmd_clear),
    .cmd_run   (cmd_run),
    .cmd_step  (cmd_step),
    .cmd_stop  (cmd_stop),
    .period    (period),
    .gen_limit (gen_limit),
    .board_rst (board_rst),
    .board_ena (board_ena),
    .busy      (busy),
    .done      (done),
    .gen_count (gen_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic next_cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic c, input logic r, input logic s, input logic p);
    cmd_clear = c;
    cmd_run   = r;
    cmd_step  = s;
    cmd_stop  = p;
    next_cycle(1);
    cmd_clear = 1'b0;
    cmd_run   = 1'b0;
    cmd_step  = 1'b0;
    cmd_stop  = 1'b0;
  endtask

  task automatic queues_empty(input string tag);
    check({tag, "_ena_left"}, 32'(ena_q.size()), 32'd0);
    check({tag, "_rst_left"}, 32'(rst_q.size()), 32'd0);
    check({tag, "_done_left"}, 32'(done_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    int exp;
    if (mon_on) begin
      if (board_ena === 1'b1) begin
        exp = (ena_q.size() != 0) ? ena_q.pop_front() : -1;
        check("ena_cycle", 32'(cyc), 32'(exp));
      end
      if (done === 1'b1) begin
        exp = (done_q.size() != 0) ? done_q.pop_front() : -1;
        check("done_cycle", 32'(cyc), 32'(exp));
      end
    end
    if (mon_rst && board_rst === 1'b1) begin
      exp = (rst_q.size() != 0) ? rst_q.pop_front() : -1;
      check("board_rst_cycle", 32'(cyc), 32'(exp));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset values, and board_rst held one cycle past reset release
    next_cycle(3);
    check("rst_board_rst", 32'(board_rst), 32'd1);
    check("rst_board_ena", 32'(board_ena), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_gen_count", 32'(gen_count), 32'd0);
    rst = 1'b0;
    check("rst_release_hold", 32'(board_rst), 32'd1);
    next_cycle(1);
    check("rst_release_drop", 32'(board_rst), 32'd0);
    mon_on  = 1'b1;
    mon_rst = 1'b1;

    // clear
    t = cyc;
    rst_q.push_back(t + 1);
    issue(1'b1, 1'b0, 1'b0, 1'b0);
    check("clear_busy", 32'(busy), 32'd0);
    next_cycle(3);
    check("clear_gen_count", 32'(gen_count), 32'd0);
    queues_empty("clear");

    // three single steps, 4 cycles apart
    for (int i = 0; i < 3; i++) begin
      t = cyc;
      ena_q.push_back(t + 1);
      issue(1'b0, 1'b0, 1'b1, 1'b0);
      check("step_busy", 32'(busy), 32'd1);
      next_cycle(3);
    end
    check("step_gen_count", 32'(gen_count), 32'd3);
    check("step_idle_busy", 32'(busy), 32'd0);
    queues_empty("step");

    // period 5, limit 4
    t = cyc;
    rst_q.push_back(t + 1);
    issue(1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle(2);
    period    = 8'd5;
    gen_limit = 4'd4;
    t = cyc;
    for (int k = 1; k <= 4; k++) ena_q.push_back(t + 5 * k);
    done_q.push_back(t + 20);
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle(9);
    check("run5_busy", 32'(busy), 32'd1);
    check("run5_mid_count", 32'(gen_count), 32'd1);
    next_cycle(11);
    check("run5_end_busy", 32'(busy), 32'd0);
    check("run5_gen_count", 32'(gen_count), 32'd4);
    queues_empty("run5");

    // period 0 acts as 1, stop six cycles after run
    t = cyc;
    rst_q.push_back(t + 1);
    issue(1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle(2);
    period    = 8'd0;
    gen_limit = 4'd0;
    t = cyc;
    for (int k = 1; k <= 6; k++) ena_q.push_back(t + k);
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle(5);
    issue(1'b0, 1'b0, 1'b0, 1'b1);
    check("stop_busy", 32'(busy), 32'd0);
    next_cycle(2);
    check("stop_gen_count", 32'(gen_count), 32'd6);
    queues_empty("stop");

    // stop+clear+step together in RUN, then clear+step together in IDLE
    period = 8'd3;
    t = cyc;
    ena_q.push_back(t + 3);
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle(3);
    issue(1'b1, 1'b0, 1'b1, 1'b1);
    check("multi_busy", 32'(busy), 32'd0);
    check("multi_board_rst", 32'(board_rst), 32'd0);
    next_cycle(3);
    check("multi_gen_count", 32'(gen_count), 32'd7);
    t = cyc;
    rst_q.push_back(t + 1);
    issue(1'b1, 1'b0, 1'b1, 1'b0);
    check("clrstep_busy", 32'(busy), 32'd0);
    next_cycle(2);
    check("clrstep_gen_count", 32'(gen_count), 32'd0);
    queues_empty("multi");

    // period 1, limit 7, then reset asserted mid-RUN
    period    = 8'd1;
    gen_limit = 4'd7;
    t = cyc;
    for (int k = 1; k <= 7; k++) ena_q.push_back(t + k);
    done_q.push_back(t + 7);
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle(8);
    check("lim7_gen_count", 32'(gen_count), 32'd7);
    check("lim7_busy", 32'(busy), 32'd0);
    queues_empty("lim7");
    period    = 8'd4;
    gen_limit = 4'd0;
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    check("mid_rst_busy_before", 32'(busy), 32'd1);
    next_cycle(1);
    check("mid_rst_count_before", 32'(gen_count), 32'd7);
    mon_rst = 1'b0;
    rst = 1'b1;
    next_cycle(1);
    rst = 1'b0;
    check("mid_rst_gen_count", 32'(gen_count), 32'd0);
    check("mid_rst_board_ena", 32'(board_ena), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_board_rst", 32'(board_rst), 32'd1);
    next_cycle(1);
    check("mid_rst_board_rst_drop", 32'(board_rst), 32'd0);
    mon_rst = 1'b1;
    next_cycle(6);
    check("mid_rst_quiet_count", 32'(gen_count), 32'd0);

    // limit below entry count fires only after gen_count wraps
    period    = 8'd1;
    gen_limit = 4'd5;
    t = cyc;
    for (int k = 1; k <= 5; k++) ena_q.push_back(t + k);
    done_q.push_back(t + 5);
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle(6);
    check("pre_wrap_count", 32'(gen_count), 32'd5);
    gen_limit = 4'd3;
    t = cyc;
    for (int k = 1; k <= 14; k++) ena_q.push_back(t + k);
    done_q.push_back(t + 14);
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle(16);
    check("wrap_gen_count", 32'(gen_count), 32'd3);
    check("wrap_busy", 32'(busy), 32'd0);
    queues_empty("wrap");

    // period change applies at the next reload
    period    = 8'd3;
    gen_limit = 4'd0;
    t = cyc;
    ena_q.push_back(t + 3);
    ena_q.push_back(t + 6);
    ena_q.push_back(t + 12);
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle(3);
    period = 8'd6;
    next_cycle(9);
    issue(1'b0, 1'b0, 1'b0, 1'b1);
    next_cycle(6);
    check("reperiod_gen_count", 32'(gen_count), 32'd6);
    check("reperiod_busy", 32'(busy), 32'd0);
    queues_empty("reperiod");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
